param_rr_fifo_arbiter: RTL and testbench

PARAM_RR_FIFO_ARBITER -- requirements
Module: param_rr_fifo_arbiter

---
 rtl/rr_fifo_pkg.sv | 15 +
 rtl/rr_chan_fifo.sv | 57 +++++
 rtl/param_rr_fifo_arbiter.sv | 93 +++++++++
 tb/tb_param_rr_fifo_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/rr_fifo_pkg.sv
// Shared defaults and helpers for the round-robin FIFO arbiter.
package rr_fifo_pkg;
  localparam int N_CH_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rr_chan_fifo.sv
// Single-channel FIFO: DEPTH x DW storage, count-based full/empty,
// registered drop pulse for writes refused while full.
module rr_chan_fifo
  import rr_fifo_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic          drop
);
  localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH) + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr, do_rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];
  assign do_wr = wen & ~full;
  assign do_rd = pop & ~empty;

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH (power of 2); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Judged on pre-edge fullness, so a same-edge pop does not rescue it.
      drop <= wen & full;
    end
  end
endmodule

// File: rtl/param_rr_fifo_arbiter.sv
// N_CH per-channel FIFOs feeding one registered output through a
// rotating-priority arbiter. Slot is refilled whenever it is empty or
// being consumed; ptr moves past the last granted channel.
module param_rr_fifo_arbiter
  import rr_fifo_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      wen,
  input  logic [N_CH*DW-1:0]   din,
  input  logic                 ready,
  output logic [DW-1:0]        dout,
  output logic                 valid,
  output logic [N_CH-1:0]      full,
  output logic [N_CH-1:0]      drop
);
  localparam int PW = clog2(N_CH);

  typedef struct packed {
    logic          hit;
    logic [PW-1:0] idx;
  } grant_t;

  logic [N_CH-1:0][DW-1:0] head;
  logic [N_CH-1:0]         empty;
  logic [N_CH-1:0]         pop;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           ptr_nxt;
  grant_t                  gnt;
  logic                    slot_free;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rr_chan_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wen   (wen[i]),
      .din   (din[i*DW +: DW]),
      .pop   (pop[i]),
      .dout  (head[i]),
      .empty (empty[i]),
      .full  (full[i]),
      .drop  (drop[i])
    );
  end

  assign slot_free = ~valid | ready;
  assign ptr_nxt   = (int'(gnt.idx) == N_CH - 1) ? '0 : gnt.idx + 1'b1;

  // First non-empty channel scanning ptr, ptr+1, ... modulo N_CH.
  always_comb begin
    int            j;
    logic [PW-1:0] cand;
    gnt  = '0;
    j    = 0;
    cand = '0;
    for (int k = 0; k < N_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      cand = PW'(j);
      if (!gnt.hit && !empty[cand]) begin
        gnt.hit = 1'b1;
        gnt.idx = cand;
      end
    end
  end

  // Pop only the granted channel, and only when the slot can take it.
  always_comb begin
    pop = '0;
    if (slot_free && gnt.hit) pop[gnt.idx] = 1'b1;
  end

  // Output register and rotate pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else if (slot_free) begin
      if (gnt.hit) begin
        dout  <= head[gnt.idx];
        valid <= 1'b1;
        ptr   <= ptr_nxt;
      end else begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_param_rr_fifo_arbiter.sv
// Directed bench for param_rr_fifo_arbiter at default parameters.
module tb_param_rr_fifo_arbiter;
  localparam int N_CH = 4;
  localparam int DW   = 8;

  logic                clk;
  logic                rst;
  logic [N_CH-1:0]     wen;
  logic [N_CH*DW-1:0]  din;
  logic                ready;
  logic [DW-1:0]       dout;
  logic                valid;
  logic [N_CH-1:0]     full;
  logic [N_CH-1:0]     drop;

  int checks   = 0;
  int failures = 0;

  param_rr_fifo_arbiter #(.N_CH(N_CH), .DW(DW), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .wen   (wen),
    .din   (din),
    .ready (ready),
    .dout  (dout),
    .valid (valid),
    .full  (full),
    .drop  (drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; drive and sample 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    wen   = '0;
    din   = '0;
    ready = 1'b1;

    // Reset with writes pending: nothing may be captured.
    #1;
    wen = 4'b1111;
    din = {8'd12, 8'd9, 8'd56, 8'd87};
    tick(); tick();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_dout",  32'(dout),  0);
    chk("rst_drop",  32'(drop),  0);
    chk("rst_full",  32'(full),  0);
    wen = '0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_valid", 32'(valid), 0);
    end

    // Four channels written at one edge drain in channel order.
    wen = 4'b1111;
    din = {8'd12, 8'd9, 8'd56, 8'd87};
    tick();
    wen = '0;
    chk("no_bypass", 32'(valid), 0);
    tick(); chk("rr0_valid", 32'(valid), 1); chk("rr0_dout", 32'(dout), 87);
    tick(); chk("rr1_valid", 32'(valid), 1); chk("rr1_dout", 32'(dout), 56);
    tick(); chk("rr2_valid", 32'(valid), 1); chk("rr2_dout", 32'(dout), 9);
    tick(); chk("rr3_valid", 32'(valid), 1); chk("rr3_dout", 32'(dout), 12);
    tick(); chk("rr_done_valid", 32'(valid), 0);

    // Skip-empty: ptr=0, ch3 then ch2 written on consecutive edges.
    wen = 4'b1000;
    din = {8'd85, 8'd0, 8'd0, 8'd0};
    tick();
    wen = 4'b0100;
    din = {8'd0, 8'd129, 8'd0, 8'd0};
    tick();
    wen = '0;
    chk("skip0_valid", 32'(valid), 1); chk("skip0_dout", 32'(dout), 85);
    tick();
    chk("skip1_valid", 32'(valid), 1); chk("skip1_dout", 32'(dout), 129);
    tick();
    chk("skip_done_valid", 32'(valid), 0);

    // Overflow: park 77 (ch1) in the held output slot first, so all five
    // ch0 writes land in the FIFO and the fifth is the one refused.
    ready = 1'b0;
    wen = 4'b0010;
    din = {8'd0, 8'd0, 8'd77, 8'd0};
    tick();
    wen = 4'b0001;
    din = {24'd0, 8'd1};
    tick();
    chk("ovf_slot_dout", 32'(dout), 77);
    din = {24'd0, 8'd2}; tick();
    din = {24'd0, 8'd3}; tick();
    din = {24'd0, 8'd4}; tick();
    chk("ovf_full_at4", 32'(full), 1);
    chk("ovf_nodrop_at4", 32'(drop), 0);
    din = {24'd0, 8'd5}; tick();
    chk("ovf_drop", 32'(drop), 1);
    chk("ovf_full_at5", 32'(full), 1);
    wen = '0;
    tick();
    chk("ovf_drop_once", 32'(drop), 0);
    chk("ovf_hold_dout", 32'(dout), 77);
    ready = 1'b1;
    tick(); chk("ovf_out1", 32'(dout), 1); chk("ovf_full_clr", 32'(full), 0);
    tick(); chk("ovf_out2", 32'(dout), 2);
    tick(); chk("ovf_out3", 32'(dout), 3);
    tick(); chk("ovf_out4", 32'(dout), 4); chk("ovf_out4_valid", 32'(valid), 1);
    tick(); chk("ovf_done_valid", 32'(valid), 0);

    // Backpressure: 51 (ch1) held three cycles, 52 (ch2) waits behind it.
    ready = 1'b0;
    wen = 4'b0110;
    din = {8'd0, 8'd52, 8'd51, 8'd0};
    tick();
    wen = '0;
    tick();
    chk("bp_load", 32'(dout), 51);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_dout", 32'(dout), 51);
      chk("bp_hold_valid", 32'(valid), 1);
    end
    ready = 1'b1;
    tick();
    chk("bp_next_dout", 32'(dout), 52);
    chk("bp_next_valid", 32'(valid), 1);
    tick();
    chk("bp_done_valid", 32'(valid), 0);

    // Mid-stream reset with six entries queued.
    ready = 1'b0;
    wen = 4'b1111;
    din = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    wen = 4'b0011;
    din = {8'd0, 8'd0, 8'd6, 8'd5};
    tick();
    wen = '0;
    tick();
    chk("mid_pre_valid", 32'(valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_valid", 32'(valid), 0);
    chk("mid_async_dout",  32'(dout),  0);
    tick();
    rst   = 1'b0;
    ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mid_post_valid", 32'(valid), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
